// File: rtl/rf_op_sequencer_pkg.sv
// Shared definitions for the register-file operation sequencer.
//   - opcode constants for the 3-bit command opcode
//   - FSM state encoding
//   - register-file address width
package rf_op_sequencer_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_op_sequencer_alu.sv
// Combinational ALU for the sequencer.
// Ports:
//   op     : 3-bit opcode
//   a, b   : N-bit operands read from the register file
//   imm    : N-bit immediate (LDI only)
//   result : N-bit result, wraps modulo 2^N
//   zero   : result == 0
//   carry  : carry-out (ADD), borrow (SUB/CMP), shifted-out MSB (SHL), else 0
module rf_op_alu
    import rf_op_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] imm,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         carry
);

    // Everything is computed one bit wider so that bit N carries the
    // carry/borrow/shifted-out bit; logic ops and LDI leave it 0.
    logic [N:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:         wide = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};
            OP_AND:         wide = {1'b0, a & b};
            OP_OR:          wide = {1'b0, a | b};
            OP_XOR:         wide = {1'b0, a ^ b};
            OP_SHL:         wide = {a, 1'b0};
            OP_LDI:         wide = {1'b0, imm};
            default:        wide = '0;
        endcase
    end

    assign result = wide[N-1:0];
    assign carry  = wide[N];
    assign zero   = (wide[N-1:0] == '0);

endmodule

// File: rtl/rf_op_sequencer.sv
// Multi-cycle controller for an 8-entry 2R/1W register file.
// One command is accepted over cmd_valid/cmd_ready, then the block walks
// IDLE -> READ -> EXEC -> WRITE, writing the destination 3 edges after
// acceptance. Throughput is one command every 4 cycles.
// Ports:
//   clock, reset             : rising-edge clock, async active-high reset
//   cmd_valid / cmd_ready    : command handshake
//   cmd_op/src1/src2/dst/imm : command fields
//   rf_addr1/2, rf_z1/2      : register file read ports
//   rf_addr3/we/wdata        : register file write port
//   done                     : one-cycle retire pulse (WRITE state)
//   result, flag_z, flag_c   : last computed result and flags
module rf_op_sequencer
    import rf_op_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_src1,
    input  logic [REG_ADDR_W-1:0] cmd_src2,
    input  logic [REG_ADDR_W-1:0] cmd_dst,
    input  logic [N-1:0]          cmd_imm,
    output logic [REG_ADDR_W-1:0] rf_addr1,
    output logic [REG_ADDR_W-1:0] rf_addr2,
    output logic [REG_ADDR_W-1:0] rf_addr3,
    output logic                  rf_we,
    output logic [N-1:0]          rf_wdata,
    input  logic [N-1:0]          rf_z1,
    input  logic [N-1:0]          rf_z2,
    output logic                  done,
    output logic [N-1:0]          result,
    output logic                  flag_z,
    output logic                  flag_c
);

    state_t state, state_next;

    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic [N-1:0]          imm_q, a_q, b_q;

    logic [N-1:0] alu_result;
    logic         alu_zero, alu_carry;

    rf_op_alu #(.N(N)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake/strobe outputs. CMP computes flags but
    // never writes the register file.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rf_we      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = S_READ;
            end
            S_READ:  state_next = S_EXEC;
            S_EXEC:  state_next = S_WRITE;
            S_WRITE: begin
                rf_we      = (op_q != OP_CMP);
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath registers: command capture in IDLE, operand latch in READ,
    // result/flags in EXEC. Operands are latched before the write, so
    // src == dst aliasing reads the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            imm_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        src1_q <= cmd_src1;
                        src2_q <= cmd_src2;
                        dst_q  <= cmd_dst;
                        imm_q  <= cmd_imm;
                    end
                end
                S_READ: begin
                    a_q <= rf_z1;
                    b_q <= rf_z2;
                end
                S_EXEC: begin
                    result <= alu_result;
                    flag_z <= alu_zero;
                    flag_c <= alu_carry;
                end
                default: ;
            endcase
        end
    end

    // Addresses come straight from the captured command, so they hold
    // their last value outside READ/WRITE.
    assign rf_addr1 = src1_q;
    assign rf_addr2 = src2_q;
    assign rf_addr3 = dst_q;
    assign rf_wdata = result;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer with a behavioural register file.
module tb_rf_op_sequencer;

    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [2:0]   cmd_src1 = '0;
    logic [2:0]   cmd_src2 = '0;
    logic [2:0]   cmd_dst = '0;
    logic [N-1:0] cmd_imm = '0;
    logic [2:0]   rf_addr1, rf_addr2, rf_addr3;
    logic         rf_we;
    logic [N-1:0] rf_wdata, rf_z1, rf_z2, result;
    logic         done, flag_z, flag_c;

    rf_op_sequencer #(.N(N)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_z1(rf_z1), .rf_z2(rf_z2),
        .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clock = ~clock;

    // Behavioural register file: combinational reads, write on rising edge.
    logic [N-1:0] regs [8];
    assign rf_z1 = regs[rf_addr1];
    assign rf_z2 = regs[rf_addr2];
    always @(posedge clock) if (rf_we) regs[rf_addr3] <= rf_wdata;

    int cycleCount = 0;
    always @(posedge clock) cycleCount <= cycleCount + 1;

    typedef struct {
        string        name;
        logic [2:0]   dst;
        logic [N-1:0] wdata;
        logic         we;
        logic         z;
        logic         c;
        int           acceptEdge;
    } exp_t;

    exp_t expQ[$];
    int compared = 0;
    int mismatched = 0;
    int weCount = 0;
    int doneCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: whenever the DUT retires a command, pop the expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (rf_we) weCount++;
            if (rf_we && !done) checkOutput("we_without_done", 1, 0);
            if (done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput({e.name, "_latency"}, cycleCount - e.acceptEdge, 2);
                    checkOutput({e.name, "_we"}, rf_we, e.we);
                    if (e.we) checkOutput({e.name, "_addr3"}, rf_addr3, e.dst);
                    checkOutput({e.name, "_wdata"}, rf_wdata, e.wdata);
                    checkOutput({e.name, "_result"}, result, e.wdata);
                    checkOutput({e.name, "_flag_z"}, flag_z, e.z);
                    checkOutput({e.name, "_flag_c"}, flag_c, e.c);
                end
            end
        end
    end

    // Issue one command starting at a falling edge; returns at the falling
    // edge after the accepting rising edge. keep leaves cmd_valid high so
    // the next call can present a new command back-to-back.
    task automatic applyStimulus(input string name, input logic [2:0] op,
                                 input logic [2:0] s1, input logic [2:0] s2,
                                 input logic [2:0] dst, input logic [N-1:0] imm,
                                 input logic [N-1:0] expData, input logic expWe,
                                 input logic expZ, input logic expC,
                                 input bit retire, input bit keep,
                                 output int acceptEdge);
        bit accepted = 0;
        exp_t e;
        cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = dst; cmd_imm = imm;
        cmd_valid = 1'b1;
        acceptEdge = -1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (cmd_ready) begin
                accepted = 1;
                acceptEdge = cycleCount + 1;
                if (retire) begin
                    e.name = name; e.dst = dst; e.wdata = expData; e.we = expWe;
                    e.z = expZ; e.c = expC; e.acceptEdge = acceptEdge;
                    expQ.push_back(e);
                end
                @(posedge clock);
                @(negedge clock);
                checkOutput({name, "_ready_drop"}, cmd_ready, 0);
            end else begin
                @(negedge clock);
            end
        end
        if (!accepted) checkOutput({name, "_accept_timeout"}, 0, 1);
        if (!keep || !accepted) cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput({name, "_retire_timeout"}, expQ.size(), 0);
            expQ.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int a0, a1, a2, prevWe, prevDone;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_we", rf_we, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", {flag_z, flag_c}, 0);
        checkOutput("rst_addrs", {rf_addr1, rf_addr2, rf_addr3}, 0);
        checkOutput("rst_wdata", rf_wdata, 0);

        // 1: LDI r1 = 0x05
        applyStimulus("ldi_r1", 3'b110, 0, 0, 1, 8'h05, 8'h05, 1, 0, 0, 1, 0, a0);
        waitIdle("ldi_r1");
        checkOutput("r1_after_ldi", regs[1], 8'h05);
        checkOutput("ldi_r1_done_count", doneCount, 1);

        // 2: LDI r2 = 0xFE; ADD r3 = r1 + r2 = 0x103 -> 0x03, carry
        applyStimulus("ldi_r2", 3'b110, 0, 0, 2, 8'hFE, 8'hFE, 1, 0, 0, 1, 0, a0);
        applyStimulus("add_r3", 3'b000, 1, 2, 3, 8'h00, 8'h03, 1, 0, 1, 1, 0, a0);
        waitIdle("add_r3");
        checkOutput("r3_after_add", regs[3], 8'h03);

        // 3: CMP r1,r1 -> zero, no write; SUB r4 = 0x05 - 0xFE = 0x07, borrow
        prevWe = weCount;
        applyStimulus("cmp_r1", 3'b111, 1, 1, 1, 8'h00, 8'h00, 0, 1, 0, 1, 0, a0);
        waitIdle("cmp_r1");
        checkOutput("cmp_no_write", weCount, prevWe);
        checkOutput("r1_after_cmp", regs[1], 8'h05);
        applyStimulus("sub_r4", 3'b001, 1, 2, 4, 8'h00, 8'h07, 1, 0, 1, 1, 0, a0);
        waitIdle("sub_r4");
        checkOutput("r4_after_sub", regs[4], 8'h07);

        // 4: three LDIs with cmd_valid held high throughout
        applyStimulus("ldi_r6", 3'b110, 0, 0, 6, 8'hA5, 8'hA5, 1, 0, 0, 1, 1, a0);
        applyStimulus("ldi_r7", 3'b110, 0, 0, 7, 8'h3C, 8'h3C, 1, 0, 0, 1, 1, a1);
        applyStimulus("ldi_r0", 3'b110, 0, 0, 0, 8'h80, 8'h80, 1, 0, 0, 1, 0, a2);
        waitIdle("b2b");
        checkOutput("b2b_gap1", a1 - a0, 4);
        checkOutput("b2b_gap2", a2 - a1, 4);
        checkOutput("r6_after_b2b", regs[6], 8'hA5);
        checkOutput("r7_after_b2b", regs[7], 8'h3C);
        checkOutput("r0_after_b2b", regs[0], 8'h80);

        // 5: SHL r2 = 0xFE << 1 = 0xFC, MSB out; XOR r5 = r2 ^ r2 = 0
        applyStimulus("shl_r2", 3'b101, 2, 0, 2, 8'h00, 8'hFC, 1, 0, 1, 1, 0, a0);
        waitIdle("shl_r2");
        checkOutput("r2_after_shl", regs[2], 8'hFC);
        applyStimulus("xor_r5", 3'b100, 2, 2, 5, 8'h00, 8'h00, 1, 1, 0, 1, 0, a0);
        waitIdle("xor_r5");
        checkOutput("r5_after_xor", regs[5], 8'h00);

        // 6: ADD to r6 aborted by an asynchronous reset during EXEC
        prevWe = weCount;
        prevDone = doneCount;
        applyStimulus("add_abort", 3'b000, 1, 2, 6, 8'h00, 8'h00, 1, 0, 0, 0, 0, a0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_ready", cmd_ready, 1);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_we", rf_we, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_flag_z", flag_z, 0);
        checkOutput("abort_flag_c", flag_c, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("abort_no_write", weCount, prevWe);
        checkOutput("abort_no_done", doneCount, prevDone);
        checkOutput("r6_after_abort", regs[6], 8'hA5);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #20000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] timeout");
    end

endmodule
